// File: rtl/mem_arbiter.sv
// Round-robin arbiter: NUM_CONSUMERS LSU read/write requesters share one memory read port and one write port, one transaction in flight.
// Latency: request edge E -> mem valid after E+1 -> consumer ready pulse after E+2 (zero-wait memory). Optional MEM_ARB_WRITE_PRIORITY_EN grants writes first.
// Backpressure: mem valid/address/data held until mem ready; requests stay pending, and valid is ignored while pending is set.
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);
    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, DONE} state_t;

    state_t                   state;
    logic [NUM_CONSUMERS-1:0] pend_rd, pend_wr, clr_rd, clr_wr;
    logic [ADDR_BITS-1:0]     rd_addr_q [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]     wr_addr_q [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]     wr_data_q [NUM_CONSUMERS];
    logic [PTR_W-1:0]         rr_ptr, winner, pick;
    logic                     pick_vld, pick_rd, cur_rd;

    // Scan from the farthest candidate down so the nearest one to rr_ptr is the last to assign.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        pick_rd  = 1'b0;
`ifdef MEM_ARB_WRITE_PRIORITY_EN
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            if (pend_wr[idx]) begin
                pick     = PTR_W'(idx);
                pick_vld = 1'b1;
            end
        end
        if (!pick_vld) begin
            for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
                if (pend_rd[idx]) begin
                    pick     = PTR_W'(idx);
                    pick_vld = 1'b1;
                    pick_rd  = 1'b1;
                end
            end
        end
`else
        for (int k = NUM_CONSUMERS - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            if (pend_rd[idx] || pend_wr[idx]) begin
                pick     = PTR_W'(idx);
                pick_vld = 1'b1;
                pick_rd  = pend_rd[idx];
            end
        end
`endif
    end

    always_comb begin
        clr_rd = '0;
        clr_wr = '0;
        if (state == DONE) begin
            if (cur_rd) clr_rd[winner] = 1'b1;
            else        clr_wr[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            winner               <= '0;
            cur_rd               <= 1'b0;
            pend_rd              <= '0;
            pend_wr              <= '0;
            rd_addr_q            <= '{default: '0};
            wr_addr_q            <= '{default: '0};
            wr_data_q            <= '{default: '0};
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
        end else begin
            // A new request landing on the clearing edge re-arms the pending bit.
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                if (consumer_read_valid[i] && (!pend_rd[i] || clr_rd[i])) begin
                    pend_rd[i]   <= 1'b1;
                    rd_addr_q[i] <= consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
                end else if (clr_rd[i]) begin
                    pend_rd[i] <= 1'b0;
                end
                if (consumer_write_valid[i] && (!pend_wr[i] || clr_wr[i])) begin
                    pend_wr[i]   <= 1'b1;
                    wr_addr_q[i] <= consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
                    wr_data_q[i] <= consumer_write_data[i*DATA_BITS +: DATA_BITS];
                end else if (clr_wr[i]) begin
                    pend_wr[i] <= 1'b0;
                end
            end

            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;

            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        winner <= pick;
                        cur_rd <= pick_rd;
                        if (pick_rd) begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= rd_addr_q[pick];
                            state            <= READ_WAIT;
                        end else begin
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= wr_addr_q[pick];
                            mem_write_data    <= wr_data_q[pick];
                            state             <= WRITE_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (mem_read_ready) begin
                        mem_read_valid                                   <= 1'b0;
                        consumer_read_data[winner*DATA_BITS +: DATA_BITS] <= mem_read_data;
                        consumer_read_ready[winner]                      <= 1'b1;
                        state                                            <= DONE;
                    end
                end
                WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        mem_write_valid              <= 1'b0;
                        consumer_write_ready[winner] <= 1'b1;
                        state                        <= DONE;
                    end
                end
                DONE: begin
                    rr_ptr <= (winner == PTR_W'(NUM_CONSUMERS - 1)) ? '0 : winner + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
